mem_port_arbiter: RTL and testbench

Arbiter and sequencer for a single-ported, synchronous-read unified memory shared by the pipeline's instruction-fetch stage and its MEM stage. Grants at most one access per cycle, with data-port priority and bounded fetch starvation. Routes the read data returned one cycle later back to the correct requester and holds it. Raises per-port stall signals for the hazard and pipeline-register enables.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg : read-owner state encodings and memory access codes
// Revision : 1.0
// ============================================================================
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_IF = 2'd1,
    ST_RD_D  = 2'd2
  } state_e;

  localparam logic [2:0] F3_WORD = 3'b010;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : fetch/data arbiter for a single-ported synchronous-read
//                    memory, with bounded fetch starvation and read routing
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              stall_d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               w_starve;
  logic               w_unused_addr;

  // Fetch addresses are word-aligned and both ports only drive ADDR_W bits.
  assign w_unused_addr = ^{d_addr, if_addr};

  assign w_starve = if_req & (starve_cnt_q == CNT_MAX);
  assign d_gnt    = d_req & ~w_starve & ~rst;
  assign if_gnt   = if_req & ~d_gnt & ~rst;
  assign stall_if = if_req & ~if_gnt;
  assign stall_d  = d_req & ~d_gnt;
  assign mem_en   = if_gnt | d_gnt;

  assign if_rvalid = (state_q == ST_RD_IF);
  assign d_rvalid  = (state_q == ST_RD_D);
  // Returned word is visible in its rvalid cycle, then held from the register.
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr[ADDR_W-1:0];
      mem_wdata = d_wdata;
      mem_func3 = d_func3;
    end else if (if_gnt) begin
      mem_addr  = {if_addr[ADDR_W-1:2], 2'b00};
      mem_func3 = F3_WORD;
    end
  end

  always_comb begin
    state_d      = ST_IDLE;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    if (if_gnt)                state_d = ST_RD_IF;
    else if (d_gnt && !d_we)   state_d = ST_RD_D;

    if (if_gnt || !if_req)              starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_MAX)   starve_cnt_d = starve_cnt_q + 1'b1;

    if (if_rvalid) if_rdata_d = mem_rdata;
    if (d_rvalid)  d_rdata_d  = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench with a small memory model
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_func3;
  logic        if_gnt, if_rvalid, stall_if;
  logic        d_gnt, d_rvalid, stall_d;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  logic [31:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .stall_d(stall_d),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory: data for a read appears the cycle after it.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_func3 = 3'b010;
    tick(); tick(); settle();
    total++; if (if_gnt !== 1'b0)    begin bad++; $display("FAIL rst_if_gnt got=%0h exp=0", if_gnt); end
    total++; if (d_gnt !== 1'b0)     begin bad++; $display("FAIL rst_d_gnt got=%0h exp=0", d_gnt); end
    total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL rst_mem_en got=%0h exp=0", mem_en); end
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", {if_rvalid, d_rvalid}); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    total++; if (d_rdata !== 32'h0)  begin bad++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
    total++; if ({stall_if, stall_d} !== 2'b11) begin bad++; $display("FAIL rst_stall got=%b exp=11", {stall_if, stall_d}); end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h13; settle();
    total++; if (if_gnt !== 1'b1)     begin bad++; $display("FAIL fetch_gnt got=%0h exp=1", if_gnt); end
    total++; if (mem_addr !== 8'h10)  begin bad++; $display("FAIL fetch_addr got=%h exp=10", mem_addr); end
    total++; if ({mem_we, mem_func3} !== 4'b0010) begin bad++; $display("FAIL fetch_we_f3 got=%b exp=0010", {mem_we, mem_func3}); end
    total++; if (stall_if !== 1'b0)   begin bad++; $display("FAIL fetch_stall got=%0h exp=0", stall_if); end
    tick(); if_req = 1'b0; settle();
    total++; if (if_rvalid !== 1'b1)  begin bad++; $display("FAIL fetch_rvalid got=%0h exp=1", if_rvalid); end
    total++; if (if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
    tick(); settle();
    total++; if (if_rvalid !== 1'b0)  begin bad++; $display("FAIL fetch_rvalid_off got=%0h exp=0", if_rvalid); end
    total++; if (if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_hold got=%h exp=00500093", if_rdata); end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h24;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_func3 = 3'b010; settle();
    total++; if ({d_gnt, if_gnt} !== 2'b10) begin bad++; $display("FAIL cont_gnt got=%b exp=10", {d_gnt, if_gnt}); end
    total++; if (stall_if !== 1'b1)   begin bad++; $display("FAIL cont_stall_if got=%0h exp=1", stall_if); end
    total++; if (mem_addr !== 8'h40)  begin bad++; $display("FAIL cont_addr got=%h exp=40", mem_addr); end
    tick(); d_req = 1'b0; settle();
    total++; if (d_rvalid !== 1'b1)   begin bad++; $display("FAIL cont_d_rvalid got=%0h exp=1", d_rvalid); end
    total++; if (d_rdata !== 32'h11223344) begin bad++; $display("FAIL cont_d_rdata got=%h exp=11223344", d_rdata); end
    total++; if (if_gnt !== 1'b1)     begin bad++; $display("FAIL cont_if_gnt got=%0h exp=1", if_gnt); end
    total++; if (mem_addr !== 8'h24)  begin bad++; $display("FAIL cont_if_addr got=%h exp=24", mem_addr); end
    tick(); if_req = 1'b0; settle();
    total++; if (if_rdata !== 32'hCAFE0024) begin bad++; $display("FAIL cont_if_rdata got=%h exp=cafe0024", if_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int cyc = 0; cyc < 5; cyc++) begin
      settle();
      total++;
      if ({if_gnt, d_gnt, stall_if, stall_d} !== ((cyc == 3) ? 4'b1001 : 4'b0110)) begin
        bad++;
        $display("FAIL starve_c%0d got=%b exp=%b", cyc, {if_gnt, d_gnt, stall_if, stall_d},
                 (cyc == 3) ? 4'b1001 : 4'b0110);
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_func3 = 3'b010; settle();
    total++; if ({d_gnt, mem_en, mem_we} !== 3'b111) begin bad++; $display("FAIL st_ctl got=%b exp=111", {d_gnt, mem_en, mem_we}); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_wdata got=%h exp=deadbeef", mem_wdata); end
    total++; if (mem_addr !== 8'h20)  begin bad++; $display("FAIL st_addr got=%h exp=20", mem_addr); end
    tick(); d_req = 1'b0; d_we = 1'b0; settle();
    total++; if (d_rvalid !== 1'b0)   begin bad++; $display("FAIL st_no_rvalid got=%0h exp=0", d_rvalid); end
    total++; if (d_rdata !== 32'h11223344) begin bad++; $display("FAIL st_hold got=%h exp=11223344", d_rdata); end
    tick(); d_req = 1'b1; d_addr = 32'h20; settle();
    total++; if ({d_gnt, mem_we} !== 2'b10) begin bad++; $display("FAIL ld_ctl got=%b exp=10", {d_gnt, mem_we}); end
    tick(); d_req = 1'b0; settle();
    total++; if (d_rvalid !== 1'b1)   begin bad++; $display("FAIL ld_rvalid got=%0h exp=1", d_rvalid); end
    total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 32'h10; settle();
    total++; if (if_gnt !== 1'b1)     begin bad++; $display("FAIL rmr_gnt got=%0h exp=1", if_gnt); end
    tick(); if_req = 1'b0; rst = 1'b1;
    tick(); settle();
    total++; if (if_rvalid !== 1'b0)  begin bad++; $display("FAIL rmr_rvalid got=%0h exp=0", if_rvalid); end
    total++; if (if_rdata !== 32'h0)  begin bad++; $display("FAIL rmr_rdata got=%h exp=0", if_rdata); end
    total++; if (d_rdata !== 32'h0)   begin bad++; $display("FAIL rmr_d_rdata got=%h exp=0", d_rdata); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h00500093;
    mem[8'h24] = 32'hCAFE0024;
    mem[8'h40] = 32'h11223344;
    mem_rdata = 32'h0;
    test_reset();
    test_fetch();
    test_contention();
    test_starvation();
    test_store_load();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
